pipeline_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the RV32IM core. It replaces the hardwired per-interface `en = 1` / `sync_rst = 0` ties with generated enable and flush vectors. It covers load-use stalls, EX-stage control redirects and multi-cycle M-extension operations (divider), and adds a multi-cycle watchdog plus stall/flush performance counters. It sits in the core top beside the Controller and drives every PipelineInterface `*_en` / `*_sync_rst` pin and the PC enable.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// multi-cycle FSM encoding and parameter legality helpers.
package pipe_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;

    localparam int MIN_STAGES     = 5;
    localparam int MIN_MC_TIMEOUT = 2;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    function automatic bit stages_ok(input int n);
        return n >= MIN_STAGES;
    endfunction

    function automatic bit timeout_ok(input int t);
        return t >= MIN_MC_TIMEOUT;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Width-parametrised saturating event counter with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Generates PC enable plus per-interface enable/flush vectors for the core
// pipeline from load-use, redirect and multi-cycle (divider) hazards.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_read,
    input  logic                  id_rs2_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  ex_mc_start,
    input  logic                  mc_done,
    output logic                  pc_en,
    output logic [NUM_STAGES-2:0] stage_en,
    output logic [NUM_STAGES-2:0] stage_flush,
    output logic                  mc_busy,
    output logic                  mc_timeout_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam bit STAGES_OK  = stages_ok(NUM_STAGES);
    localparam bit TIMEOUT_OK = timeout_ok(MC_TIMEOUT);

    generate
        if (!STAGES_OK) begin : g_bad_stages
            $error("pipeline_hazard_ctrl: NUM_STAGES must be at least 5");
        end
        if (!TIMEOUT_OK) begin : g_bad_timeout
            $error("pipeline_hazard_ctrl: MC_TIMEOUT must be at least 2");
        end
    endgenerate

    localparam int              WD_W    = $clog2(MC_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    mc_state_t       mc_state;
    logic [WD_W-1:0] wdog_cnt;
    logic            mc_release;
    logic            lu;
    logic            mc_stall;
    logic            redirect_taken;
    logic            stall_inc;

    // Hazard detection and stage control (combinational, same-cycle decision)
    always_comb begin
        lu = ex_mem_read && (ex_rd != '0) &&
             ((id_rs1_read && (id_rs1 == ex_rd)) ||
              (id_rs2_read && (id_rs2 == ex_rd)));

        // After a watchdog abort the stuck op still shows ex_mc_start for one
        // cycle while it drains out of EX; mc_release keeps it from re-arming.
        mc_stall = ((mc_state == MC_IDLE) && ex_mc_start && !mc_done && !mc_release) ||
                   ((mc_state == MC_BUSY) && !mc_done);

        pc_en       = 1'b1;
        stage_en    = '1;
        stage_flush = '0;

        if (sync_rst) begin
            pc_en       = 1'b0;
            stage_flush = '1;
        end else if (mc_stall) begin
            pc_en               = 1'b0;
            stage_en[STG_IF]    = 1'b0;
            stage_en[STG_ID]    = 1'b0;
            stage_flush[STG_EX] = 1'b1;
        end else if (ex_redirect) begin
            stage_flush[STG_IF] = 1'b1;
            stage_flush[STG_ID] = 1'b1;
        end else if (lu) begin
            pc_en               = 1'b0;
            stage_en[STG_IF]    = 1'b0;
            stage_flush[STG_ID] = 1'b1;
        end

        redirect_taken = !sync_rst && !mc_stall && ex_redirect;
        stall_inc      = !sync_rst && !pc_en;
    end

    // Multi-cycle FSM with watchdog
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            mc_state       <= MC_IDLE;
            wdog_cnt       <= '0;
            mc_timeout_err <= 1'b0;
            mc_release     <= 1'b0;
        end else begin
            mc_release <= 1'b0;
            case (mc_state)
                MC_IDLE: begin
                    wdog_cnt <= '0;
                    if (ex_mc_start && !mc_done && !mc_release) begin
                        mc_state <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    if (mc_done) begin
                        mc_state <= MC_IDLE;
                        wdog_cnt <= '0;
                    end else if (wdog_cnt == WD_LAST) begin
                        mc_state       <= MC_IDLE;
                        wdog_cnt       <= '0;
                        mc_timeout_err <= 1'b1;
                        mc_release     <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                default: begin
                    mc_state <= MC_IDLE;
                    wdog_cnt <= '0;
                end
            endcase
        end
    end

    assign mc_busy = (mc_state == MC_BUSY);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (sync_rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (sync_rst),
        .inc (redirect_taken),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controller instances (default and short-timeout/narrow
// counters) share stimulus; a cycle model predicts every output.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_read, id_rs2_read, ex_mem_read, ex_redirect, ex_mc_start, mc_done;

    logic        pc_en_a, busy_a, err_a;
    logic [3:0]  en_a, fl_a;
    logic [31:0] scnt_a, fcnt_a;
    logic        pc_en_b, busy_b, err_b;
    logic [3:0]  en_b, fl_b;
    logic [3:0]  scnt_b, fcnt_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(32), .MC_TIMEOUT(64)) dut_a (
        .clk(clk), .sync_rst(sync_rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
        .mc_done(mc_done), .pc_en(pc_en_a), .stage_en(en_a), .stage_flush(fl_a),
        .mc_busy(busy_a), .mc_timeout_err(err_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
    );

    pipeline_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(4), .MC_TIMEOUT(8)) dut_b (
        .clk(clk), .sync_rst(sync_rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
        .mc_done(mc_done), .pc_en(pc_en_b), .stage_en(en_b), .stage_flush(fl_b),
        .mc_busy(busy_b), .mc_timeout_err(err_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
    );

    always @(posedge clk) begin
        if (!sync_rst && ex_redirect && !mc_done)
            assert (!busy_a && !busy_b) else $error("protocol violation: redirect while busy");
    end

    typedef struct {
        bit     busy;
        int     wd;
        bit     err;
        bit     rel;
        longint scnt;
        longint fcnt;
    } mdl_t;

    typedef struct {
        bit       pc;
        bit [3:0] en;
        bit [3:0] fl;
        bit       busy;
        bit       err;
        longint   scnt;
        longint   fcnt;
    } exp_t;

    mdl_t ma, mb;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t predict(input mdl_t m);
        exp_t e;
        bit   lu, mcs;
        lu  = ex_mem_read && (ex_rd != 0) &&
              ((id_rs1_read && id_rs1 == ex_rd) || (id_rs2_read && id_rs2 == ex_rd));
        mcs = m.busy ? !mc_done : (ex_mc_start && !mc_done && !m.rel);
        e.pc = 1'b1; e.en = 4'b1111; e.fl = 4'b0000;
        if (sync_rst) begin
            e.pc = 1'b0; e.fl = 4'b1111;
        end else if (mcs) begin
            e.pc = 1'b0; e.en = 4'b1100; e.fl = 4'b0100;
        end else if (ex_redirect) begin
            e.fl = 4'b0011;
        end else if (lu) begin
            e.pc = 1'b0; e.en = 4'b1110; e.fl = 4'b0010;
        end
        e.busy = m.busy; e.err = m.err; e.scnt = m.scnt; e.fcnt = m.fcnt;
        return e;
    endfunction

    function automatic mdl_t advance(input mdl_t m, input exp_t e, input int to, input longint cmax);
        mdl_t n;
        n = m;
        if (sync_rst) begin
            n = '{busy: 1'b0, wd: 0, err: 1'b0, rel: 1'b0, scnt: 0, fcnt: 0};
        end else begin
            if (!e.pc && n.scnt < cmax) n.scnt++;
            if (e.fl[0] && n.fcnt < cmax) n.fcnt++;
            n.rel = 1'b0;
            if (!m.busy) begin
                n.wd = 0;
                if (ex_mc_start && !mc_done && !m.rel) n.busy = 1'b1;
            end else if (mc_done) begin
                n.busy = 1'b0; n.wd = 0;
            end else if (m.wd + 1 == to) begin
                n.busy = 1'b0; n.wd = 0; n.err = 1'b1; n.rel = 1'b1;
            end else begin
                n.wd = m.wd + 1;
            end
        end
        return n;
    endfunction

    task automatic run_cycle();
        exp_t ea, eb, x;
        ea = predict(ma);
        eb = predict(mb);
        sbq.push_back(ea);
        sbq.push_back(eb);
        @(negedge clk);
        x = sbq.pop_front();
        chk("a_pc_en", 64'(pc_en_a), 64'(x.pc));
        chk("a_stage_en", 64'(en_a), 64'(x.en));
        chk("a_stage_flush", 64'(fl_a), 64'(x.fl));
        chk("a_mc_busy", 64'(busy_a), 64'(x.busy));
        chk("a_timeout_err", 64'(err_a), 64'(x.err));
        chk("a_stall_cnt", 64'(scnt_a), x.scnt);
        chk("a_flush_cnt", 64'(fcnt_a), x.fcnt);
        x = sbq.pop_front();
        chk("b_pc_en", 64'(pc_en_b), 64'(x.pc));
        chk("b_stage_en", 64'(en_b), 64'(x.en));
        chk("b_stage_flush", 64'(fl_b), 64'(x.fl));
        chk("b_mc_busy", 64'(busy_b), 64'(x.busy));
        chk("b_timeout_err", 64'(err_b), 64'(x.err));
        chk("b_stall_cnt", 64'(scnt_b), x.scnt);
        chk("b_flush_cnt", 64'(fcnt_b), x.fcnt);
        ma = advance(ma, ea, 64, 64'hFFFF_FFFF);
        mb = advance(mb, eb, 8, 15);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic quiet();
        sync_rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_read = 1'b0; id_rs2_read = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_rs1_read = 1'b1;
    endtask

    initial begin
        quiet();
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        ma = '{busy: 1'b0, wd: 0, err: 1'b0, rel: 1'b0, scnt: 0, fcnt: 0};
        mb = ma;

        run_n(2);                                   // reset outputs
        quiet();
        run_n(2);                                   // normal flow

        set_lu(5'd5);                               // load-use stall
        run_cycle();
        quiet();
        run_cycle();                                // bubble in EX
        set_lu(5'd0);                               // x0 never hazards
        run_cycle();
        quiet();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_read = 1'b1;
        run_cycle();                                // rs2 match
        quiet();
        id_rs1 = 5'd7; ex_rd = 5'd7; ex_mem_read = 1'b1;
        run_cycle();                                // match but rs1 not read

        quiet();
        set_lu(5'd5); ex_redirect = 1'b1;           // redirect beats load-use
        run_cycle();
        quiet();
        ex_redirect = 1'b1;
        run_cycle();
        quiet();
        run_cycle();

        ex_mc_start = 1'b1;                         // 33-cycle divide
        run_n(33);
        mc_done = 1'b1;
        run_cycle();
        quiet();
        run_n(2);

        ex_mc_start = 1'b1; mc_done = 1'b1;         // single-cycle op
        run_cycle();
        quiet();
        run_cycle();

        ex_mc_start = 1'b1;                         // short watchdog expires
        run_n(12);
        mc_done = 1'b1;
        run_cycle();
        quiet();
        run_n(2);

        set_lu(5'd5);                               // 20 stall cycles
        run_n(20);
        quiet();
        run_cycle();

        ex_mc_start = 1'b1;                         // reset mid-busy
        run_n(4);
        sync_rst = 1'b1;
        run_n(2);
        quiet();
        run_n(3);

        for (int i = 0; i < 300; i++) begin
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            ex_rd       = 5'($urandom_range(0, 7));
            id_rs1_read = ($urandom_range(0, 1) == 1);
            id_rs2_read = ($urandom_range(0, 1) == 1);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_mc_start = ($urandom_range(0, 3) == 0);
            mc_done     = ($urandom_range(0, 4) == 0);
            ex_redirect = (!ma.busy && !mb.busy) ? ($urandom_range(0, 5) == 0) : 1'b0;
            sync_rst    = ($urandom_range(0, 40) == 0);
            run_cycle();
        end

        quiet();
        run_n(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
